// File: rtl/scope_sync_pkg.sv
// Shared types for the scope clock-domain sample synchronisers.
package scope_sync_pkg;

    localparam int SAMPLE_W  = 12;
    localparam int OVR_CNT_W = 8;

    typedef logic [SAMPLE_W-1:0]  sample_t;
    typedef logic [OVR_CNT_W-1:0] ovr_cnt_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        HOLD    = 2'd2
    } f2s_state_t;

    function automatic ovr_cnt_t sat_inc(input ovr_cnt_t cnt);
        return (cnt == '1) ? cnt : cnt + ovr_cnt_t'(1);
    endfunction

endpackage

// File: rtl/fast_to_slow_sync_if.sv
// Sample handshake and held-output bundle between the fast sample path and the slow domain.
interface fast_to_slow_sync_if;
    import scope_sync_pkg::*;

    sample_t d;
    logic    d_valid;
    logic    d_ready;
    sample_t q;
    logic    q_update;

    modport master (output d, d_valid, input d_ready, q, q_update);
    modport slave  (input d, d_valid, output d_ready, q, q_update);

endinterface

// File: rtl/sync_edge_detect.sv
// Three-flop synchroniser for a slow clock sampled as data, with rise/fall detection.
module sync_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = s3 & ~s2;

endmodule

// File: rtl/fast_to_slow_sync.sv
// Hands fast-clock samples to a slow-domain register that only changes after a slow falling edge.
// Build option FAST_TO_SLOW_LATEST_EN: no backpressure, latest sample wins, overruns counted.
//
// state   | meaning
// EMPTY   | nothing pending, ready for a sample
// PENDING | sample waiting for the next slow falling edge
// HOLD    | q loaded, waiting for the slow domain to see one rising edge
module fast_to_slow_sync
    import scope_sync_pkg::*;
(
    input  logic                      fast_clk,
    input  logic                      reset_n,
    input  logic                      slow_clk,
    fast_to_slow_sync_if.slave        bus
`ifdef FAST_TO_SLOW_LATEST_EN
    ,
    output ovr_cnt_t                  overrun_cnt
`endif
);

`ifdef FAST_TO_SLOW_LATEST_EN
    localparam bit LATEST = 1'b1;
`else
    localparam bit LATEST = 1'b0;
`endif

    f2s_state_t state;
    sample_t    pend;
    logic       pend_full;
    sample_t    q_r;
    logic       q_update_r;
    logic       ready_q;
    logic       rise;
    logic       fall;
    logic       accept;

    sync_edge_detect u_sync (
        .clk      (fast_clk),
        .reset_n  (reset_n),
        .async_in (slow_clk),
        .rise     (rise),
        .fall     (fall)
    );

    assign bus.d_ready  = ready_q | LATEST;
    assign bus.q        = q_r;
    assign bus.q_update = q_update_r;
    assign accept       = bus.d_valid & bus.d_ready;

    always_ff @(posedge fast_clk) begin
        if (!reset_n) begin
            state      <= EMPTY;
            pend       <= '0;
            pend_full  <= 1'b0;
            q_r        <= '0;
            q_update_r <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            q_update_r <= 1'b0;
            case (state)
                EMPTY: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        pend    <= bus.d;
                        state   <= PENDING;
                        ready_q <= 1'b0;
                    end
                end
                PENDING: begin
                    ready_q <= 1'b0;
                    if (fall) begin
                        q_r        <= pend;
                        q_update_r <= 1'b1;
                        pend_full  <= 1'b0;
                        state      <= HOLD;
                        ready_q    <= 1'b1;
                        // Only reachable without backpressure: the new sample queues behind q.
                        if (accept) begin
                            pend      <= bus.d;
                            pend_full <= 1'b1;
                            ready_q   <= 1'b0;
                        end
                    end else if (accept) begin
                        pend <= bus.d;
                    end
                end
                HOLD: begin
                    if (rise) begin
                        if (pend_full || accept) begin
                            state     <= PENDING;
                            pend_full <= 1'b0;
                            ready_q   <= 1'b0;
                        end else begin
                            state   <= EMPTY;
                            ready_q <= 1'b1;
                        end
                        if (accept) begin
                            pend <= bus.d;
                        end
                    end else if (accept) begin
                        pend      <= bus.d;
                        pend_full <= 1'b1;
                        ready_q   <= 1'b0;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef FAST_TO_SLOW_LATEST_EN
    logic overwrite;

    assign overwrite = accept && ((state == PENDING && !fall) || (state == HOLD && pend_full));

    always_ff @(posedge fast_clk) begin
        if (!reset_n) begin
            overrun_cnt <= '0;
        end else if (overwrite) begin
            overrun_cnt <= sat_inc(overrun_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_fast_to_slow_sync.sv
// Directed self-checking bench for fast_to_slow_sync (100 ns fast clock, 1000 ns slow clock).
module tb_fast_to_slow_sync;
    import scope_sync_pkg::*;

    logic fast_clk;
    logic slow_clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   cyc;
    int   n_upd;
    bit   prev_upd;
    bit   dbl;

    fast_to_slow_sync_if bus ();

`ifdef FAST_TO_SLOW_LATEST_EN
    ovr_cnt_t overrun_cnt;
    localparam logic EXP_RST_READY = 1'b1;
`else
    localparam logic EXP_RST_READY = 1'b0;
`endif

    fast_to_slow_sync dut (
        .fast_clk    (fast_clk),
        .reset_n     (reset_n),
        .slow_clk    (slow_clk),
        .bus         (bus)
`ifdef FAST_TO_SLOW_LATEST_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    initial begin
        fast_clk = 1'b0;
        forever #50 fast_clk = ~fast_clk;
    end

    // Slow edges land 30 ns before a fast rising edge, never on one.
    initial begin
        slow_clk = 1'b0;
        #120 slow_clk = 1'b1;
        forever #500 slow_clk = ~slow_clk;
    end

    initial begin
        cyc      = 0;
        n_upd    = 0;
        prev_upd = 1'b0;
        dbl      = 1'b0;
    end

    always @(posedge fast_clk) cyc <= cyc + 1;

    always @(negedge fast_clk) begin
        if (bus.q_update === 1'b1) begin
            n_upd <= n_upd + 1;
            if (prev_upd) dbl <= 1'b1;
        end
        prev_upd <= (bus.q_update === 1'b1);
    end

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_update(input int budget, output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.q_update === 1'b1) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        bit got;
        int lat;
        int t_a;
        int t_b;
        int n0;
        bit seen_777;

        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        bus.d       = '0;
        bus.d_valid = 1'b0;

        // Reset with slow_clk toggling
        repeat (3) tick();
        check("rst_q", 32'(bus.q), 32'h000);
        check("rst_q_update", 32'(bus.q_update), 32'd0);
        check("rst_d_ready", 32'(bus.d_ready), 32'(EXP_RST_READY));
        reset_n = 1'b1;
        tick();
        check("ready_after_release", 32'(bus.d_ready), 32'd1);
        check("no_update_in_reset", 32'(n_upd), 32'd0);

`ifdef FAST_TO_SLOW_LATEST_EN
        // Latest-wins: three samples in one high phase, then saturation
        @(posedge slow_clk);
        repeat (4) tick();
        @(posedge slow_clk);
        tick();
        bus.d_valid = 1'b1;
        bus.d = 12'h111; tick();
        bus.d = 12'h222; tick();
        bus.d = 12'h123; tick();
        bus.d_valid = 1'b0;
        wait_update(12, got, lat);
        check("latest_got", 32'(got), 32'd1);
        check("latest_q", 32'(bus.q), 32'h123);
        check("latest_ovr2", 32'(overrun_cnt), 32'd2);
        bus.d_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bus.d = sample_t'(i);
            tick();
        end
        bus.d_valid = 1'b0;
        check("latest_ovr_sat", 32'(overrun_cnt), 32'd255);
`else
        // Single sample accepted while slow_clk is high
        @(posedge slow_clk);
        repeat (4) tick();
        check("idle_ready", 32'(bus.d_ready), 32'd1);
        bus.d = 12'hEFF; bus.d_valid = 1'b1;
        tick();
        bus.d_valid = 1'b0;
        check("pend_ready_low", 32'(bus.d_ready), 32'd0);
        check("q_before_fall", 32'(bus.q), 32'h000);
        @(negedge slow_clk);
        wait_update(8, got, lat);
        check("single_got", 32'(got), 32'd1);
        check("single_lat_le4", 32'(lat >= 1 && lat <= 4), 32'd1);
        check("single_q", 32'(bus.q), 32'hEFF);
        tick();
        check("single_pulse_width", 32'(bus.q_update), 32'd0);
        check("single_pulse_count", 32'(n_upd), 32'd1);
        @(posedge slow_clk);
        #1;
        check("q_stable_at_rise", 32'(bus.q), 32'hEFF);

        // Backpressure: 0xEAE, then 0xAAA in HOLD, 0x123 held off
        repeat (4) tick();
        check("bp_idle_ready", 32'(bus.d_ready), 32'd1);
        bus.d = 12'hEAE; bus.d_valid = 1'b1;
        tick();
        bus.d = 12'h123;
        check("bp_pending_ready_low", 32'(bus.d_ready), 32'd0);
        tick();
        check("bp_pending_still_low", 32'(bus.d_ready), 32'd0);
        bus.d_valid = 1'b0;
        wait_update(12, got, lat);
        check("bp_eae_got", 32'(got), 32'd1);
        check("bp_eae_q", 32'(bus.q), 32'hEAE);
        t_a = cyc;
        check("bp_hold_ready", 32'(bus.d_ready), 32'd1);
        bus.d = 12'hAAA; bus.d_valid = 1'b1;
        tick();
        bus.d = 12'h123;
        check("bp_hold_full_ready_low", 32'(bus.d_ready), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.d_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("bp_ready_reopen", 32'(got), 32'd1);
        check("bp_reopen_with_update", 32'(bus.q_update), 32'd1);
        check("bp_aaa_q", 32'(bus.q), 32'hAAA);
        t_b = cyc;
        check("bp_eae_to_aaa_cycles", 32'(t_b - t_a), 32'd10);
        tick();
        bus.d_valid = 1'b0;
        check("bp_123_taken", 32'(bus.d_ready), 32'd0);
        wait_update(15, got, lat);
        check("bp_123_got", 32'(got), 32'd1);
        check("bp_123_q", 32'(bus.q), 32'h123);
        check("bp_aaa_to_123_cycles", 32'(cyc - t_b), 32'd10);

        // Accept on exactly the rise cycle in HOLD
        @(posedge slow_clk);
        tick();
        tick();
        bus.d = 12'h5A5; bus.d_valid = 1'b1;
        tick();
        bus.d_valid = 1'b0;
        check("sim_ready_low", 32'(bus.d_ready), 32'd0);
        check("sim_q_held", 32'(bus.q), 32'h123);
        wait_update(12, got, lat);
        check("sim_got", 32'(got), 32'd1);
        check("sim_q", 32'(bus.q), 32'h5A5);

        // Reset while 0x777 is pending
        @(posedge slow_clk);
        repeat (4) tick();
        bus.d = 12'h777; bus.d_valid = 1'b1;
        tick();
        bus.d_valid = 1'b0;
        reset_n = 1'b0;
        n0 = n_upd;
        repeat (3) tick();
        check("mid_rst_q", 32'(bus.q), 32'h000);
        check("mid_rst_ready", 32'(bus.d_ready), 32'd0);
        reset_n = 1'b1;
        seen_777 = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.q === 12'h777) seen_777 = 1'b1;
        end
        check("mid_rst_no_777", 32'(seen_777), 32'd0);
        check("mid_rst_no_update", 32'(n_upd - n0), 32'd0);
        @(posedge slow_clk);
        repeat (4) tick();
        check("resume_ready", 32'(bus.d_ready), 32'd1);
        bus.d = 12'h3C3; bus.d_valid = 1'b1;
        tick();
        bus.d_valid = 1'b0;
        wait_update(12, got, lat);
        check("resume_got", 32'(got), 32'd1);
        check("resume_q", 32'(bus.q), 32'h3C3);
`endif

        tick();
        check("no_back_to_back_update", 32'(dbl), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fast_to_slow_sync.md
# fast_to_slow_sync

- Transfers 12-bit samples produced at the fast clock rate into a register the slow-clock logic can sample safely. It is the fast-to-slow counterpart of `slow_to_fast_sync`.
- The whole block runs on `fast_clk`; `slow_clk` enters only as an asynchronous data input that is synchronised and edge-detected.
- The output `q` changes only just after a slow falling edge, so it is stable at every slow rising edge.
- It sits between the fast sample path (trigger/decimation) and slow-domain display/readout logic.

## Interface
- `W`, 12, sample width.
- `fast_clk`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `slow_clk`  in  1  slow clock, sampled as asynchronous data.
- `d`  in  W  sample from fast domain.
- `d_valid`  in  1  `d` valid this cycle.
- `d_ready`  out  1  block accepts `d` this cycle; a transfer occurs when `d_valid` and `d_ready` are both high.
- `q`  out  W  held sample for the slow domain.
- `q_update`  out  1  one-cycle pulse on the cycle `q` is loaded.
- `overrun_cnt`  out  8  present only with `FAST_TO_SLOW_LATEST_EN`.

## Operation
**Synchroniser**
- Three flops: `s1 <= slow_clk`, `s2 <= s1`, `s3 <= s2`.
- `fall = s3 & ~s2`; `rise = s2 & ~s3` (both combinational).

**Storage**
- `pend` (W bits) and `pend_full` (1 bit).
- FSM states: EMPTY, PENDING, HOLD.

**EMPTY**
- `d_ready` = 1.
- On accept: `pend <= d`, go to PENDING.
- `fall`/`rise` are ignored.

**PENDING**
- `d_ready` = 0.
- On `fall`: `q <= pend`, `q_update` = 1, `pend_full <= 0`, go to HOLD.

**HOLD** (`q` is held until the slow domain has seen one rising edge)
- `d_ready` = `~pend_full`.
- On accept: `pend <= d`, `pend_full <= 1`.
- On `rise`: go to PENDING if `pend_full`, or if an accept occurs in the same cycle; otherwise go to EMPTY. `pend_full` clears on the move to PENDING.
- `fall` in HOLD without an intervening `rise` is ignored.

**Boundary cases**
- Accept and `rise` in the same cycle: the data is captured and the next state is PENDING.
- `q` never changes except on `fall` in PENDING.
- Reset mid-operation discards `pend`; no `q_update` is issued.

**Reset values** (while `reset_n` is low at a clock edge)
- `q` = 0, `q_update` = 0, `d_ready` = 0, state = EMPTY.
- `s1`/`s2`/`s3` = 0, `pend` = 0, `pend_full` = 0, `overrun_cnt` = 0.
- `d_ready` becomes 1 on the first cycle after release.

## Timing
**Latency**
- `slow_clk` edge to `fall`/`rise`: 3 fast rising edges after the first edge that samples the new level.
- `q` and `q_update` are registered; `q` is valid on the cycle the `q_update` pulse is high.

**Clock-ratio requirement**
- The slow half-period must be at least 5 fast periods, so `q` settles well before the next slow rising edge.
- The bench uses a 100 ns fast period and a 1000 ns slow period (ratio 10).

**Throughput**
- At most one sample per slow period reaches `q`.
- `d_ready` is never high in PENDING (in default mode).

**Output discipline**
- `q_update` is never asserted on two consecutive cycles.
- Successive `q_update` pulses are at least one slow period apart.

## Configuration
**`FAST_TO_SLOW_LATEST_EN` undefined (default)**
- Backpressure mode as described above.
- No `overrun_cnt` port.

**`FAST_TO_SLOW_LATEST_EN` defined**
- `d_ready` is tied to 1 (including during reset).
- An accept in PENDING, or in HOLD with `pend_full`, overwrites `pend`, so the latest sample wins.
- Each such overwrite increments `overrun_cnt`, saturating at 255.
- All other transitions are unchanged.

## Structure
- Package `scope_sync_pkg` holds:
  - `SAMPLE_W` = 12.
  - `typedef logic [SAMPLE_W-1:0] sample_t`.
  - State enum `f2s_state_t` {EMPTY, PENDING, HOLD}.
  - `OVR_CNT_W` = 8.
- One sub-module, `sync_edge_detect`:
  - Holds the 3-flop synchroniser with reset.
  - Outputs `rise` and `fall`.
  - Reusable by `slow_to_fast_sync`.
- Top level contains the FSM, `pend`, `q` and the counter.

## Test plan
1. **Reset.** Hold `reset_n` low for 3 cycles with `slow_clk` toggling → `q` = 0x000, `q_update` never high, `d_ready` = 0 then 1 on the first post-release cycle.
2. **Single sample.** Accept `d` = 0xEFF while `slow_clk` is high → `q` = 0xEFF with a single `q_update` pulse, ≤ 4 fast cycles after the next slow falling edge; `q` is stable across the following slow rising edge.
3. **Backpressure.** Accept 0xEAE, then 0xAAA during HOLD, then offer 0x123:
   - `d_ready` is low in PENDING for 0x123.
   - `d_ready` is low for 0x123 in HOLD once `pend_full` is set.
   - `q` sequence is 0xEAE then 0xAAA, one slow period apart.
   - 0x123 is accepted only after the second rise.
4. **Simultaneous event.** Assert `d_valid` with 0x5A5 on exactly the `rise` cycle in HOLD → next state is PENDING, and `q` = 0x5A5 after the next fall.
5. **Reset mid-operation.** Assert reset in PENDING holding 0x777 → 0x777 never appears on `q`, `q` = 0x000, and normal transfer resumes after release.
6. **Latest-wins** (macro defined). Accept 0x111, 0x222, 0x123 within one slow high phase → `q` = 0x123 after the fall, `overrun_cnt` = 2; 300 further overwrites → `overrun_cnt` = 255.
